// File: rtl/mm_res_collector.sv
// mm_res_collector
//   Receiving end of the cascaded FIOS Montgomery multiplier chain. Gathers the
//   17-bit result limbs (LSB limb first) into the full-width product T. While
//   gathering, it also computes T - p one limb at a time with a rippling borrow.
//   It then applies the final conditional subtraction
//   (result = T >= p ? T - p : T) and offers the result on a valid/ready
//   handshake.
//
// Ports
//   clock_i       system clock, rising edge
//   reset_i       asynchronous active-high reset
//   start_i       one-cycle pulse, opens (or restarts) a result frame
//   limb_valid_i  limb_i carries a result limb this cycle
//   limb_i        17-bit result limb
//   p_i           modulus, 17*S bits, stable from start_i until handshake
//   res_o         reduced result
//   res_valid_o   res_o valid
//   res_ready_i   consumer accepts res_o
//   busy_o        high whenever the FSM is not IDLE
//   err_o         one-cycle pulse the cycle after a limb was dropped
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start_i; stray limbs are dropped and flagged
// COLLECT | accepting limbs; gaps hold state, start_i restarts the frame
// DECIDE  | final borrow selects T or T - p into res_o (one cycle)
// OUT     | res_o held; res_valid_o offered until res_ready_i

module mm_res_collector #(
  parameter int S = 16
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            limb_valid_i,
  input  logic [16:0]     limb_i,
  input  logic [17*S-1:0] p_i,
  output logic [17*S-1:0] res_o,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic            busy_o,
  output logic            err_o
);

  localparam int W  = 17 * S;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            borrow;
  logic [W-1:0]    coll;
  logic [W-1:0]    diff;

  // A start_i pulse makes the current limb slot 0 with no incoming borrow,
  // so a limb arriving together with start_i is taken as limb 0 of the frame.
  logic [CW-1:0]   idx;
  logic            borrow_in;
  logic [16:0]     p_limb;
  logic [17:0]     sub;
  logic            last;

  always_comb begin
    idx       = start_i ? '0 : cnt;
    borrow_in = start_i ? 1'b0 : borrow;
    p_limb    = '0;
    for (int i = 0; i < S; i++) begin
      if (idx == CW'(i)) p_limb = p_i[i*17 +: 17];
    end
    // Bit 17 of the 18-bit difference is the outgoing borrow.
    sub  = {1'b0, limb_i} - {1'b0, p_limb} - {17'd0, borrow_in};
    last = (idx == CW'(S - 1));
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      borrow      <= 1'b0;
      coll        <= '0;
      diff        <= '0;
      res_o       <= '0;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (state == IDLE && !start_i) begin
            if (limb_valid_i) err_o <= 1'b1;
          end else begin
            busy_o <= 1'b1;
            if (limb_valid_i) begin
              for (int i = 0; i < S; i++) begin
                if (idx == CW'(i)) begin
                  coll[i*17 +: 17] <= limb_i;
                  diff[i*17 +: 17] <= sub[16:0];
                end
              end
              borrow <= sub[17];
              cnt    <= idx + 1'b1;
              state  <= last ? DECIDE : COLLECT;
            end else begin
              cnt    <= idx;
              borrow <= borrow_in;
              state  <= COLLECT;
            end
          end
        end

        DECIDE: begin
          if (limb_valid_i) err_o <= 1'b1;
          // A final borrow means T < p. T == p leaves no borrow and gives 0.
          res_o <= borrow ? coll : diff;
          state <= OUT;
        end

        OUT: begin
          if (limb_valid_i) err_o <= 1'b1;
          // res_o settles for one cycle before res_valid_o is raised.
          // The transfer is only counted once valid is visible.
          if (!res_valid_o) begin
            res_valid_o <= 1'b1;
          end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          res_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
